// File: rtl/ex_result_queue.sv
// EX-stage result queue: merges ALU and multiplier results into one ordered stream, at most one packet every other cycle.
// Optional macro EX_RESULT_QUEUE_BYPASS_EN loads an offer straight into ex_reg when the queue is empty and idle.

package ex_result_queue_pkg;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned RES_W = 32;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [RES_W-1:0] alu_result;
  } ex_packet_t;
endpackage

module ex_result_queue
  import ex_result_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  ex_packet_t             alu_pkt,
  input  ex_packet_t             mult_pkt,
  input  logic                   flush,
  output logic                   alu_stall,
  output logic                   mult_stall,
  output ex_packet_t             ex_reg,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  ex_packet_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] w_tail1;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_free;
  ex_packet_t       r_ex;
  ex_packet_t       w_ex_nxt;
  ex_packet_t       w_wr0;
  ex_packet_t       w_wr1;
  logic             w_acc_m;
  logic             w_acc_a;
  logic             w_pop;
  logic             w_byp;
  logic             w_nonempty;
  logic [1:0]       w_n_push;

  // Stalls look only at registered occupancy, so a same-cycle pop never opens room.
  assign w_free     = CNT_W'(DEPTH) - r_count;
  assign mult_stall = (w_free == '0);
  assign alu_stall  = (w_free < CNT_W'(2));

  assign w_acc_m    = mult_pkt.valid & ~mult_stall & ~flush;
  assign w_acc_a    = alu_pkt.valid & ~alu_stall & ~flush;
  assign w_nonempty = (r_count != '0);
  assign w_tail1    = PTR_W'(r_tail + PTR_W'(1));

  assign ex_reg = r_ex;
  assign count  = r_count;

  // Output FSM: every presented packet is followed by a cleared cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_byp       = 1'b0;
    w_ex_nxt    = '0;
    if (!flush) begin
      case (r_state)
        S_IDLE: begin
          if (w_nonempty) begin
            w_pop          = 1'b1;
            w_ex_nxt       = r_mem[r_head];
            w_ex_nxt.valid = 1'b1;
            w_state_nxt    = S_SEND;
          end
`ifdef EX_RESULT_QUEUE_BYPASS_EN
          else if (w_acc_m || w_acc_a) begin
            w_byp          = 1'b1;
            w_ex_nxt       = w_acc_m ? mult_pkt : alu_pkt;
            w_ex_nxt.valid = 1'b1;
            w_state_nxt    = S_SEND;
          end
`endif
        end
        S_SEND: w_state_nxt = S_GAP;
        S_GAP: begin
          if (w_nonempty) begin
            w_pop          = 1'b1;
            w_ex_nxt       = r_mem[r_head];
            w_ex_nxt.valid = 1'b1;
            w_state_nxt    = S_SEND;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Enqueue list, multiplier first; a bypassed offer leaves only the ALU packet to store.
  always_comb begin
    w_wr0    = w_acc_m ? mult_pkt : alu_pkt;
    w_wr1    = alu_pkt;
    w_n_push = 2'(w_acc_m) + 2'(w_acc_a);
    if (w_byp) begin
      w_wr0    = alu_pkt;
      w_n_push = w_n_push - 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ex    <= '0;
    end else begin
      r_ex <= w_ex_nxt;
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_pop) begin
          r_head <= PTR_W'(r_head + PTR_W'(1));
        end
        r_tail  <= PTR_W'(r_tail + PTR_W'(w_n_push));
        r_count <= r_count + CNT_W'(w_n_push) - CNT_W'(w_pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_n_push != 2'd0) begin
      r_mem[r_tail] <= w_wr0;
    end
    if (w_n_push == 2'd2) begin
      r_mem[w_tail1] <= w_wr1;
    end
  end

endmodule

// File: tb/tb_ex_result_queue.sv
// Self-checking bench for ex_result_queue: scoreboard of accepted offers checked against ex_reg in order.
`timescale 1ns/1ps
module tb_ex_result_queue;
  import ex_result_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset_n;
  ex_packet_t       alu_pkt;
  ex_packet_t       mult_pkt;
  logic             flush;
  logic             alu_stall;
  logic             mult_stall;
  ex_packet_t       ex_reg;
  logic [CNT_W-1:0] count;

  int         n_checks = 0;
  int         n_errors = 0;
  ex_packet_t sb[$];
  ex_packet_t mon_exp;
  int         m_cnt = 0;
  int         m_st  = 0;
  logic       prev_valid = 1'b0;

  always #5 clock = ~clock;

  ex_result_queue #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .alu_pkt    (alu_pkt),
    .mult_pkt   (mult_pkt),
    .flush      (flush),
    .alu_stall  (alu_stall),
    .mult_stall (mult_stall),
    .ex_reg     (ex_reg),
    .count      (count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic ex_packet_t pk(input logic v, input logic [5:0] t, input logic [31:0] r);
    ex_packet_t p;
    p.valid      = v;
    p.tag        = t;
    p.alu_result = r;
    return p;
  endfunction

  // Drive one cycle of offers, advance the reference model, then check occupancy and stalls.
  task automatic step(input ex_packet_t m, input ex_packet_t a, input logic fl);
    int free;
    bit acc_m;
    bit acc_a;
    bit pop;
    mult_pkt = m;
    alu_pkt  = a;
    flush    = fl;
    free  = int'(DEPTH) - m_cnt;
    acc_m = m.valid && (free >= 1) && !fl;
    acc_a = a.valid && (free >= 2) && !fl;
    if (acc_m) sb.push_back(m);
    if (acc_a) sb.push_back(a);
    pop = 1'b0;
    if (fl) begin
      m_st = 0;
    end else begin
      case (m_st)
        0: if (m_cnt > 0) begin pop = 1'b1; m_st = 1; end
        1: m_st = 2;
        default: begin
          if (m_cnt > 0) begin pop = 1'b1; m_st = 1; end
          else m_st = 0;
        end
      endcase
    end
    @(posedge clock);
    #1;
    if (fl) begin
      m_cnt = 0;
      sb.delete();
    end else begin
      m_cnt = m_cnt + int'(acc_m) + int'(acc_a) - int'(pop);
    end
    mult_pkt = '0;
    alu_pkt  = '0;
    flush    = 1'b0;
    check("count", 64'(count), 64'(m_cnt));
    check("mult_stall", 64'(mult_stall), 64'(m_cnt == int'(DEPTH)));
    check("alu_stall", 64'(alu_stall), 64'(m_cnt >= int'(DEPTH) - 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask

  // Output monitor: in-order packets, no back-to-back valid, zero payload when invalid.
  always @(negedge clock) begin
    if (reset_n) begin
      if (ex_reg.valid) begin
        check("b2b_valid", 64'(prev_valid), 64'(0));
        if (sb.size() == 0) begin
          check("unexpected_pkt", 64'(ex_reg), 64'(0));
        end else begin
          mon_exp = sb.pop_front();
          check("ex_pkt", 64'(ex_reg), 64'(mon_exp));
        end
      end else begin
        check("idle_zero", 64'(ex_reg), 64'(0));
      end
      prev_valid = ex_reg.valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    logic pat [6];
    int   tags [6];
    pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tags = '{3, 0, 4, 0, 5, 0};

    reset_n  = 1'b0;
    alu_pkt  = '0;
    mult_pkt = '0;
    flush    = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'(0));
    check("rst_ex_reg", 64'(ex_reg), 64'(0));
    check("rst_mult_stall", 64'(mult_stall), 64'(0));
    check("rst_alu_stall", 64'(alu_stall), 64'(0));
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Single ALU offer: visible two cycles later, for one cycle only.
    step('0, pk(1'b1, 6'd5, 32'h10), 1'b0);
    check("lat_c1_valid", 64'(ex_reg.valid), 64'(0));
    idle(1);
    check("lat_c2_valid", 64'(ex_reg.valid), 64'(1));
    check("lat_c2_tag", 64'(ex_reg.tag), 64'(5));
    check("lat_c2_res", 64'(ex_reg.alu_result), 64'h10);
    idle(1);
    check("lat_c3_valid", 64'(ex_reg.valid), 64'(0));
    idle(3);

    // Dual offer: multiplier first, gap, then ALU.
    step(pk(1'b1, 6'd1, 32'h100), pk(1'b1, 6'd2, 32'h200), 1'b0);
    check("dual_cnt0", 64'(count), 64'(2));
    idle(1);
    check("dual_cnt1", 64'(count), 64'(1));
    check("dual_tag1", 64'(ex_reg.tag), 64'(1));
    idle(1);
    check("dual_gap", 64'(ex_reg.valid), 64'(0));
    idle(1);
    check("dual_cnt2", 64'(count), 64'(0));
    check("dual_tag2", 64'(ex_reg.tag), 64'(2));
    idle(4);

    // Fill to DEPTH; the extra offers are refused.
    step(pk(1'b1, 6'd10, 32'hA), pk(1'b1, 6'd11, 32'hB), 1'b0);
    step(pk(1'b1, 6'd12, 32'hC), pk(1'b1, 6'd13, 32'hD), 1'b0);
    step(pk(1'b1, 6'd14, 32'hE), pk(1'b1, 6'd15, 32'hF), 1'b0);
    check("fill_count", 64'(count), 64'(DEPTH));
    check("fill_mult_stall", 64'(mult_stall), 64'(1));
    check("fill_alu_stall", 64'(alu_stall), 64'(1));
    step(pk(1'b1, 6'd16, 32'h16), '0, 1'b0);
    idle(12);

    // Back-to-back drain of 3,4,5.
    step(pk(1'b1, 6'd3, 32'h3), pk(1'b1, 6'd4, 32'h4), 1'b0);
    step(pk(1'b1, 6'd5, 32'h5), '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("drain_valid", 64'(ex_reg.valid), 64'(pat[i]));
      check("drain_tag", 64'(ex_reg.tag), 64'(tags[i]));
      idle(1);
    end
    idle(2);

    // Flush with three queued and a same-cycle ALU offer.
    step(pk(1'b1, 6'd20, 32'h20), pk(1'b1, 6'd21, 32'h21), 1'b0);
    step(pk(1'b1, 6'd22, 32'h22), pk(1'b1, 6'd23, 32'h23), 1'b0);
    check("flush_pre_count", 64'(count), 64'(3));
    step('0, pk(1'b1, 6'd9, 32'h9), 1'b1);
    check("flush_count", 64'(count), 64'(0));
    check("flush_valid", 64'(ex_reg.valid), 64'(0));
    idle(6);

    // Asynchronous reset mid-cycle with two entries queued and one presented.
    step(pk(1'b1, 6'd30, 32'h30), pk(1'b1, 6'd31, 32'h31), 1'b0);
    step(pk(1'b1, 6'd32, 32'h32), '0, 1'b0);
    check("arst_pre_count", 64'(count), 64'(2));
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count", 64'(count), 64'(0));
    check("arst_ex_reg", 64'(ex_reg), 64'(0));
    check("arst_mult_stall", 64'(mult_stall), 64'(0));
    check("arst_alu_stall", 64'(alu_stall), 64'(0));
    sb.delete();
    m_cnt = 0;
    m_st  = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(6);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step(pk(1'($urandom_range(0, 1)), 6'($urandom), 32'($urandom)),
           pk(1'($urandom_range(0, 1)), 6'($urandom), 32'($urandom)),
           1'($urandom_range(0, 29) == 0));
    end
    idle(12);
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
